// File: rtl/s_csks12_seq.sv
// s_csks12_seq: sequential 12-bit signed carry-skip subtractor, one 4-bit block per clock (optional ovf via S_CSKS12_OVF_EN)
module s_csks12_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] a,
    input  logic [11:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [12:0] diff
`ifdef S_CSKS12_OVF_EN
    ,
    output logic        ovf
`endif
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;
    logic [11:0] a_q, nb_q;
    logic        carry;
    logic [1:0]  blk;
    logic [3:0]  a_blk, nb_blk, p, s;
    logic [4:0]  c;
    logic        c_out, sign;

    assign a_blk  = a_q[{blk, 2'b00} +: 4];
    assign nb_blk = nb_q[{blk, 2'b00} +: 4];
    assign c[0]   = carry;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign p[i]   = a_blk[i] ^ nb_blk[i];
        assign s[i]   = p[i] ^ c[i];
        assign c[i+1] = (a_blk[i] & nb_blk[i]) | (p[i] & c[i]);
    end

    // a fully propagating block forwards its carry-in, bypassing the ripple
    assign c_out = &p ? carry : c[4];
    // bit 12 extends both operands by their sign bits; only meaningful on the top block
    assign sign  = a_q[11] ^ nb_q[11] ^ c_out;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next state and handshake decodes
    always_comb begin
        state_nx  = state;
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        if (state == IDLE && in_valid)      state_nx = CALC;
        if (state == CALC && blk == 2'd2)   state_nx = DONE;
        if (state == DONE && out_ready)     state_nx = IDLE;
    end

    // operand capture and block-serial accumulation of the difference
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            nb_q  <= '0;
            carry <= 1'b0;
            blk   <= '0;
            diff  <= '0;
`ifdef S_CSKS12_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (state == IDLE && in_valid) begin
            a_q   <= a;
            nb_q  <= ~b;
            carry <= 1'b1;
            blk   <= '0;
            diff  <= '0;
`ifdef S_CSKS12_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (state == CALC) begin
            diff[{blk, 2'b00} +: 4] <= s;
            carry <= c_out;
            blk   <= blk + 2'd1;
            if (blk == 2'd2) begin
                diff[12] <= sign;
`ifdef S_CSKS12_OVF_EN
                ovf      <= sign ^ s[3];
`endif
            end
        end
    end
endmodule

// File: tb/tb_s_csks12_seq.sv
// tb_s_csks12_seq: directed vector table, handshake corner cases and randomized scoreboard for s_csks12_seq (ovf checked when S_CSKS12_OVF_EN is defined)
module tb_s_csks12_seq;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [11:0] a = '0, b = '0;
    logic        in_ready, out_valid;
    logic [12:0] diff;
`ifdef S_CSKS12_OVF_EN
    logic        ovf;
`endif
    int n_chk = 0, n_fail = 0;
    localparam int N_RND = 4000;
    localparam int MAX_CYC = 60000;

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        logic [12:0] d;
        logic        o;
    } vec_t;
    vec_t vecs[14];

    always #5 clk = ~clk;

    s_csks12_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .diff(diff)
`ifdef S_CSKS12_OVF_EN
        , .ovf(ovf)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_ovf(input string name, input logic exp);
`ifdef S_CSKS12_OVF_EN
        chk(name, 32'(ovf), 32'(exp));
`endif
    endtask

    // the difference as plain integer arithmetic on the signed operand values
    function automatic logic [12:0] ref_diff(input logic [11:0] x, input logic [11:0] y);
        int d;
        d = int'($signed(x)) - int'($signed(y));
        return d[12:0];
    endfunction

    function automatic logic ref_ovf(input logic [11:0] x, input logic [11:0] y);
        int d;
        d = int'($signed(x)) - int'($signed(y));
        return d > 2047 || d < -2048;
    endfunction

    function automatic logic [11:0] rnd_op();
        logic [11:0] r;
        r = 12'($urandom);
        case ($urandom_range(0, 7))
            0: r = 12'h7FF;
            1: r = 12'h800;
            2: r = 12'h000;
            3: r = 12'hFFF;
            default: ;
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [11:0] x, input logic [11:0] y);
        in_valid = 1'b1;
        a = x;
        b = y;
        tick();
        in_valid = 1'b0;
        a = 12'($urandom);
        b = 12'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    logic [12:0] qd[$];
    logic        qo[$];
    logic [12:0] d_seen, d_exp;
    logic        o_seen, o_exp, acc, dlv;
    int          lat, acc_n, del_n, cyc;

    initial begin
        vecs[0]  = '{12'd5,   12'd3,   13'h0002, 1'b0};
        vecs[1]  = '{12'd0,   12'd1,   13'h1FFF, 1'b0};
        vecs[2]  = '{12'h7FF, 12'h800, 13'h0FFF, 1'b1};
        vecs[3]  = '{12'h800, 12'h7FF, 13'h1001, 1'b1};
        vecs[4]  = '{12'd7,   12'hFF7, 13'h0010, 1'b0};
        vecs[5]  = '{12'hFFF, 12'hFFF, 13'h0000, 1'b0};
        vecs[6]  = '{12'd100, 12'hFE4, 13'h0080, 1'b0};
        vecs[7]  = '{12'h800, 12'h800, 13'h0000, 1'b0};
        vecs[8]  = '{12'h7FF, 12'h7FF, 13'h0000, 1'b0};
        vecs[9]  = '{12'h555, 12'hAAA, 13'h0AAB, 1'b1};
        vecs[10] = '{12'hC18, 12'h3E8, 13'h1830, 1'b0};
        vecs[11] = '{12'd0,   12'd0,   13'h0000, 1'b0};
        vecs[12] = '{12'h3E8, 12'hBE8, 13'h0800, 1'b1};
        vecs[13] = '{12'hC18, 12'h418, 13'h1800, 1'b0};

        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk_ovf("rst_ovf", 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        out_ready = 1'b1;
        for (int k = 0; k < 14; k++) begin
            start(vecs[k].a, vecs[k].b);
            chk($sformatf("v%0d_busy", k), 32'(in_ready), 32'd0);
            wait_done(lat);
            chk($sformatf("v%0d_latency", k), 32'(lat), 32'd3);
            chk($sformatf("v%0d_diff", k), 32'(diff), 32'(vecs[k].d));
            chk_ovf($sformatf("v%0d_ovf", k), vecs[k].o);
            chk($sformatf("v%0d_done_in_ready", k), 32'(in_ready), 32'd0);
            tick();
            chk($sformatf("v%0d_idle_out_valid", k), 32'(out_valid), 32'd0);
            chk($sformatf("v%0d_idle_in_ready", k), 32'(in_ready), 32'd1);
        end

        out_ready = 1'b0;
        start(12'd100, 12'hFE4);
        wait_done(lat);
        chk("bp_latency", 32'(lat), 32'd3);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            a = 12'd1;
            b = 12'd2;
            tick();
            chk("bp_diff", 32'(diff), 32'h0080);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_diff", 32'(diff), 32'h0080);

        start(12'hFFF, 12'hFFF);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_calc_in_ready", 32'(in_ready), 32'd1);
        chk("rst_calc_out_valid", 32'(out_valid), 32'd0);
        chk("rst_calc_diff", 32'(diff), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        start(12'd7, 12'hFF7);
        wait_done(lat);
        chk("post_rst_latency", 32'(lat), 32'd3);
        chk("post_rst_diff", 32'(diff), 32'h0010);
        tick();

        out_ready = 1'b0;
        start(12'h7FF, 12'h800);
        wait_done(lat);
        chk("pre_rst_done_diff", 32'(diff), 32'h0FFF);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_done_out_valid", 32'(out_valid), 32'd0);
        chk("rst_done_diff", 32'(diff), 32'd0);
        chk_ovf("rst_done_ovf", 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        acc_n = 0;
        del_n = 0;
        cyc = 0;
        while ((acc_n < N_RND || del_n < acc_n) && cyc < MAX_CYC) begin
            in_valid = (acc_n < N_RND) && ($urandom_range(0, 3) != 0);
            a = rnd_op();
            b = rnd_op();
            out_ready = $urandom_range(0, 3) != 0;
            acc = in_valid && in_ready;
            dlv = out_valid && out_ready;
            d_seen = diff;
`ifdef S_CSKS12_OVF_EN
            o_seen = ovf;
`else
            o_seen = 1'b0;
`endif
            tick();
            cyc++;
            if (acc) begin
                qd.push_back(ref_diff(a, b));
                qo.push_back(ref_ovf(a, b));
                acc_n++;
            end
            if (dlv) begin
                del_n++;
                if (qd.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rnd_extra: result 0x%0h delivered with nothing outstanding", d_seen);
                end else begin
                    d_exp = qd.pop_front();
                    o_exp = qo.pop_front();
                    chk("rnd_diff", 32'(d_seen), 32'(d_exp));
`ifdef S_CSKS12_OVF_EN
                    chk("rnd_ovf", 32'(o_seen), 32'(o_exp));
`endif
                end
            end
        end
        in_valid = 1'b0;
        chk("rnd_accepted", 32'(acc_n), 32'(N_RND));
        chk("rnd_delivered", 32'(del_n), 32'(acc_n));
        chk("rnd_outstanding", 32'(qd.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
